// File: rtl/divisibility_sweep_checker_pkg.sv
// Shared constants and state encoding for the divisibility sweep checker.
// Flag vectors are always ordered {outall, out5, out4, out3, out2}.
package div_check_pkg;

   localparam int         CODE_W    = 5;
   localparam logic [4:0] LAST_CODE = 5'd31;

   localparam int MB_2   = 0;
   localparam int MB_3   = 1;
   localparam int MB_4   = 2;
   localparam int MB_5   = 3;
   localparam int MB_ALL = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/divisibility_sweep_checker_if.sv
// Link between the sweep checker (master) and the 5-bit divisibility detector (slave).
interface div_det_if;
   logic [4:0] i;
   logic       out2;
   logic       out3;
   logic       out4;
   logic       out5;
   logic       outall;

   modport master (output i, input out2, out3, out4, out5, outall);
   modport slave  (input i, output out2, out3, out4, out5, outall);
endinterface

// File: rtl/divisibility_sweep_checker_golden.sv
// Combinational golden reference: expected divisibility flags for a 5-bit code.
module div_golden
   import div_check_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [4:0]        exp_flags
);

   logic mod3_zero;
   logic mod5_zero;

   // Table lookups keep mod-3/mod-5 to a handful of gates instead of a divider.
   always_comb begin
      mod3_zero = 1'b0;
      case (code)
         5'd0, 5'd3, 5'd6, 5'd9, 5'd12, 5'd15,
         5'd18, 5'd21, 5'd24, 5'd27, 5'd30: mod3_zero = 1'b1;
         default:                           mod3_zero = 1'b0;
      endcase
   end

   always_comb begin
      mod5_zero = 1'b0;
      case (code)
         5'd0, 5'd5, 5'd10, 5'd15, 5'd20, 5'd25, 5'd30: mod5_zero = 1'b1;
         default:                                       mod5_zero = 1'b0;
      endcase
   end

   always_comb begin
      exp_flags         = '0;
      exp_flags[MB_2]   = ~code[0];
      exp_flags[MB_3]   = mod3_zero;
      exp_flags[MB_4]   = (code[1:0] == 2'b00);
      exp_flags[MB_5]   = mod5_zero;
      exp_flags[MB_ALL] = exp_flags[MB_2] & exp_flags[MB_3] & exp_flags[MB_4] & exp_flags[MB_5];
   end

endmodule

// File: rtl/divisibility_sweep_checker.sv
// Self-test engine: sweeps codes 0..31 into the divisibility detector and checks its flags.
//   state  | meaning
//   IDLE   | waiting for start; results held
//   SETTLE | current code driven, settle down-counter running
//   CHECK  | flags compared against golden, step to next code
//   DONE   | one-cycle completion pulse, pass valid
module divisibility_sweep_checker
   import div_check_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   div_det_if.master         det,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [5:0]        err_count,
   output logic              fail_valid,
   output logic [CODE_W-1:0] fail_code,
   output logic [4:0]        fail_mask
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t              state;
   logic [3:0]          settle_cnt;
   logic [CODE_W-1:0]   code;
   logic [4:0]          exp_flags;
   logic [4:0]          flags;
   logic [4:0]          mask;
   logic                mismatch;
   logic [5:0]          err_next;

   div_golden u_golden (
      .code      (code),
      .exp_flags (exp_flags)
   );

   assign flags    = {det.outall, det.out5, det.out4, det.out3, det.out2};
   assign mask     = flags ^ exp_flags;
   assign mismatch = |mask;
   assign err_next = err_count + {5'd0, mismatch};

   assign det.i = code;
   assign busy  = (state == ST_SETTLE) || (state == ST_CHECK);
   assign done  = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         code       <= '0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_code  <= '0;
         fail_mask  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= SETTLE_LOAD;
                  code       <= '0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_code  <= '0;
                  fail_mask  <= '0;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == 4'd0) state <= ST_CHECK;
               else                    settle_cnt <= settle_cnt - 4'd1;
            end
            ST_CHECK: begin
               err_count <= err_next;
               if (mismatch && !fail_valid) begin
                  fail_valid <= 1'b1;
                  fail_code  <= code;
                  fail_mask  <= mask;
               end
               // Verdict is registered on entry so it is already valid during the done pulse.
               if (code == LAST_CODE) begin
                  state <= ST_DONE;
                  pass  <= (err_next == 6'd0);
               end else begin
                  state      <= ST_SETTLE;
                  code       <= code + 5'd1;
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divisibility_sweep_checker.sv
// Scoreboard bench for divisibility_sweep_checker with a fault-injectable detector model.
module tb_divisibility_sweep_checker;
   import div_check_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start_a, start_b, start_c;
   int   fault_a;

   div_det_if ia();
   div_det_if ib();
   div_det_if ic();

   logic       busy_a, done_a, pass_a, fv_a;
   logic [5:0] err_a;
   logic [4:0] fc_a, fm_a;
   logic       busy_b, done_b, pass_b, fv_b;
   logic [5:0] err_b;
   logic [4:0] fc_b, fm_b;
   logic       busy_c, done_c, pass_c, fv_c;
   logic [5:0] err_c;
   logic [4:0] fc_c, fm_c;

   divisibility_sweep_checker #(.SETTLE_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .det(ia), .busy(busy_a), .done(done_a),
      .pass(pass_a), .err_count(err_a), .fail_valid(fv_a), .fail_code(fc_a), .fail_mask(fm_a));
   divisibility_sweep_checker #(.SETTLE_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .det(ib), .busy(busy_b), .done(done_b),
      .pass(pass_b), .err_count(err_b), .fail_valid(fv_b), .fail_code(fc_b), .fail_mask(fm_b));
   divisibility_sweep_checker #(.SETTLE_CYCLES(15)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .det(ic), .busy(busy_c), .done(done_c),
      .pass(pass_c), .err_count(err_c), .fail_valid(fv_c), .fail_code(fc_c), .fail_mask(fm_c));

   // Detector model {outall,out5,out4,out3,out2}; fault 1 = out3 stuck 0, fault 2 = outall inverted.
   function automatic logic [4:0] det_model(input logic [4:0] c, input int fault);
      int v;
      logic [4:0] f;
      v    = int'(c);
      f[0] = (v % 2 == 0);
      f[1] = (v % 3 == 0);
      f[2] = (v % 4 == 0);
      f[3] = (v % 5 == 0);
      f[4] = f[0] & f[1] & f[2] & f[3];
      if (fault == 1) f[1] = 1'b0;
      if (fault == 2) f[4] = ~f[4];
      return f;
   endfunction

   always_comb {ia.outall, ia.out5, ia.out4, ia.out3, ia.out2} = det_model(ia.i, fault_a);
   always_comb {ib.outall, ib.out5, ib.out4, ib.out3, ib.out2} = det_model(ib.i, 0);
   always_comb {ic.outall, ic.out5, ic.out4, ic.out3, ic.out2} = det_model(ic.i, 0);

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   typedef struct {
      int acc;
      int pass;
      int errc;
      int fv;
      int fcode;
      int fmask;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t predict(input int fault, input int acc);
      exp_t e;
      logic [4:0] m;
      e.acc = acc; e.errc = 0; e.fv = 0; e.fcode = 0; e.fmask = 0;
      for (int c = 0; c < 32; c++) begin
         m = det_model(5'(c), fault) ^ det_model(5'(c), 0);
         if (m != 5'd0) begin
            e.errc++;
            if (e.fv == 0) begin
               e.fv = 1; e.fcode = c; e.fmask = int'(m);
            end
         end
      end
      e.pass = (e.errc == 0) ? 1 : 0;
      return e;
   endfunction

   exp_t got_e;
   always @(negedge clk) begin
      if (!rst && done_a) begin
         if (sb.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            got_e = sb.pop_front();
            chk("latency", cyc - got_e.acc + 1, 97);
            chk("pass", pass_a, got_e.pass);
            chk("err_count", err_a, got_e.errc);
            chk("fail_valid", fv_a, got_e.fv);
            if (got_e.fv != 0) begin
               chk("fail_code", fc_a, got_e.fcode);
               chk("fail_mask", fm_a, got_e.fmask);
            end
            chk("busy_in_done", busy_a, 0);
         end
      end
   end

   task automatic sweep_a(input int fault);
      fault_a = fault;
      sb.push_back(predict(fault, cyc + 1));
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < bound; n++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", sb.size(), 0);
      @(negedge clk);
   endtask

   task automatic check_reset_a(input string tag);
      chk({tag, "_i"}, ia.i, 0);
      chk({tag, "_busy"}, busy_a, 0);
      chk({tag, "_done"}, done_a, 0);
      chk({tag, "_pass"}, pass_a, 0);
      chk({tag, "_err"}, err_a, 0);
      chk({tag, "_fv"}, fv_a, 0);
      chk({tag, "_fcode"}, fc_a, 0);
      chk({tag, "_fmask"}, fm_a, 0);
   endtask

   task automatic sweep_timing(input int which, input int s, input int exp_lat);
      int         n, run;
      logic [4:0] prev, cur_i;
      logic       cur_busy, cur_done, cur_pass;
      bit         got;
      got = 1'b0;
      if (which == 1) start_b = 1'b1; else start_c = 1'b1;
      @(negedge clk);
      start_b = 1'b0; start_c = 1'b0;
      n    = 1;
      prev = (which == 1) ? ib.i : ic.i;
      run  = 1;
      while (n < exp_lat + 20) begin
         cur_done = (which == 1) ? done_b : done_c;
         cur_pass = (which == 1) ? pass_b : pass_c;
         if (cur_done) begin
            got = 1'b1;
            chk("latency_s", n, exp_lat);
            chk("hold_last", run, s + 1);
            chk("pass_s", cur_pass, 1);
            break;
         end
         @(negedge clk);
         n++;
         cur_i    = (which == 1) ? ib.i : ic.i;
         cur_busy = (which == 1) ? busy_b : busy_c;
         if (cur_busy) begin
            if (cur_i != prev) begin
               chk("hold_code", run, s + 1);
               prev = cur_i;
               run  = 1;
            end else run++;
         end
      end
      if (!got) chk("done_timeout_s", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; fault_a = 0;
      repeat (3) @(negedge clk);
      check_reset_a("reset");
      rst = 1'b0;
      @(negedge clk);

      sweep_a(0); wait_drain(200);
      sweep_a(1); wait_drain(200);
      sweep_a(2); wait_drain(200);

      // Stray start while busy must not produce a second done.
      sweep_a(0);
      repeat (20) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_drain(200);
      repeat (110) @(negedge clk);

      // Abort at code 17.
      sweep_a(0);
      seen = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (ia.i == 5'd17) begin
            seen = 1'b1;
            break;
         end
      end
      chk("reached_code17", seen, 1);
      rst = 1'b1;
      @(negedge clk);
      sb.delete();
      check_reset_a("abort");
      rst = 1'b0;
      repeat (120) @(negedge clk);
      sweep_a(0); wait_drain(200);

      // Start held high: back-to-back sweeps, second accepted two edges after done.
      sb.push_back(predict(0, cyc + 1));
      sb.push_back(predict(0, cyc + 1 + 98));
      fault_a = 0;
      start_a = 1'b1;
      for (int n = 0; n < 200 && sb.size() > 1; n++) begin
         @(negedge clk);
         #1;
      end
      repeat (3) @(negedge clk);
      start_a = 1'b0;
      chk("rearm_busy", busy_a, 1);
      wait_drain(200);

      sweep_timing(1, 1, 65);
      sweep_timing(2, 15, 513);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
